// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and refresh default
// for the SDRAM arbiter and its refresh timer.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    localparam int REF_CYCLES_DEF = 780;

    typedef enum logic [4:0] {
        ST_INIT    = 5'b00001,
        ST_IDLE    = 5'b00010,
        ST_REFRESH = 5'b00100,
        ST_WRITE   = 5'b01000,
        ST_READ    = 5'b10000
    } arb_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh request generator: free-running counter once init is done,
// raising ref_req on every wrap and dropping it when the refresh is granted.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF
) (
    input  logic sclk,
    input  logic reset,
    input  logic init_done,
    input  logic ref_grant,
    output logic ref_req
);

    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             wrap;

    // A wrap in the same cycle as a grant starts a new period, so setting wins.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = init_done && (cnt_q == CNT_LAST);
        req_d = req_q;
        if (init_done) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
        if (wrap) begin
            req_d = 1'b1;
        end else if (ref_grant) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign ref_req = req_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter between init, refresh, write and read engines with a
// registered pin mux. Define SDRAM_ARB_RR_EN for round-robin write/read grants.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF,
    parameter int ADDR_W     = 12,
    parameter int BA_W       = 2
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              wr_trig,
    input  logic              rd_trig,
    output logic              ref_en,
    input  logic              ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    output logic              wr_en,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    output logic              rd_en,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic              ref_req,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);

    arb_state_t        state_q, state_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              ref_en_q, wr_en_q, rd_en_q;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic              refGrant, wrGrant, rdGrant;
    logic              writeFirst;

    sdram_ref_timer #(
        .REF_CYCLES(REF_CYCLES)
    ) u_ref_timer (
        .sclk     (sclk),
        .reset    (reset),
        .init_done(init_done),
        .ref_grant(refGrant),
        .ref_req  (ref_req)
    );

`ifdef SDRAM_ARB_RR_EN
    logic last_wr_q, last_wr_d;

    assign writeFirst = wr_pend_q && !(rd_pend_q && last_wr_q);

    always_comb begin
        last_wr_d = last_wr_q;
        if (wrGrant) begin
            last_wr_d = 1'b1;
        end else if (rdGrant) begin
            last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`else
    assign writeFirst = wr_pend_q;
`endif

    // Every operation returns to IDLE, which guarantees a gap cycle between grants.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    if (init_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (ref_req) begin
                    state_d = ST_REFRESH;
                end else if (writeFirst) begin
                    state_d = ST_WRITE;
                end else if (rd_pend_q) begin
                    state_d = ST_READ;
                end
            end
            ST_REFRESH: if (ref_end) state_d = ST_IDLE;
            ST_WRITE:   if (wr_end)  state_d = ST_IDLE;
            ST_READ:    if (rd_end)  state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    assign refGrant = (state_q == ST_IDLE) && (state_d == ST_REFRESH);
    assign wrGrant  = (state_q == ST_IDLE) && (state_d == ST_WRITE);
    assign rdGrant  = (state_q == ST_IDLE) && (state_d == ST_READ);

    assign wr_pend_d = wr_trig || (wr_pend_q && !wrGrant);
    assign rd_pend_d = rd_trig || (rd_pend_q && !rdGrant);

    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        case (state_q)
            ST_INIT: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
            end
            ST_REFRESH: begin
                cmd_d  = ref_cmd;
                addr_d = ref_addr;
            end
            ST_WRITE: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
                ba_d   = wr_ba;
            end
            ST_READ: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
                ba_d   = rd_ba;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            ba_q      <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            ref_en_q  <= refGrant;
            wr_en_q   <= wrGrant;
            rd_en_q   <= rdGrant;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
        end
    end

    assign ref_en     = ref_en_q;
    assign wr_en      = wr_en_q;
    assign rd_en      = rd_en_q;
    assign sdram_cmd  = cmd_q;
    assign sdram_addr = addr_q;
    assign sdram_ba   = ba_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus queues expected grants, a monitor
// checks each start pulse and the registered pin bus that follows it.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int ADDR_W     = 12;
    localparam int BA_W       = 2;
    localparam int REF_CYCLES = 780;
    localparam int G_REF      = 1;
    localparam int G_WR       = 2;
    localparam int G_RD       = 3;

    localparam logic [ADDR_W-1:0] INIT_ADDR = 12'h0A1;
    localparam logic [ADDR_W-1:0] REF_ADDR  = 12'h400;
    localparam logic [ADDR_W-1:0] WR_ADDR   = 12'h123;
    localparam logic [ADDR_W-1:0] RD_ADDR   = 12'h456;
    localparam logic [BA_W-1:0]   WR_BA     = 2'd1;
    localparam logic [BA_W-1:0]   RD_BA     = 2'd2;

    logic              sclk = 1'b0;
    logic              reset = 1'b0;
    logic              init_done = 1'b0;
    logic              wr_trig = 1'b0;
    logic              rd_trig = 1'b0;
    logic              refEndEng = 1'b0;
    logic              wrEndEng = 1'b0;
    logic              rdEndEng = 1'b0;
    logic              rdEndExtra = 1'b0;
    logic              holdWr = 1'b0;
    logic              holdRd = 1'b0;
    logic              ref_en, wr_en, rd_en, ref_req;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;

    int errors = 0;
    int checks = 0;
    int expQ[$];

    sdram_arbiter #(
        .REF_CYCLES(REF_CYCLES),
        .ADDR_W    (ADDR_W),
        .BA_W      (BA_W)
    ) dut (
        .sclk      (sclk),
        .reset     (reset),
        .init_done (init_done),
        .init_cmd  (CMD_PRE),
        .init_addr (INIT_ADDR),
        .wr_trig   (wr_trig),
        .rd_trig   (rd_trig),
        .ref_en    (ref_en),
        .ref_end   (refEndEng),
        .ref_cmd   (CMD_REF),
        .ref_addr  (REF_ADDR),
        .wr_en     (wr_en),
        .wr_end    (wrEndEng),
        .wr_cmd    (CMD_WR),
        .wr_addr   (WR_ADDR),
        .wr_ba     (WR_BA),
        .rd_en     (rd_en),
        .rd_end    (rdEndEng | rdEndExtra),
        .rd_cmd    (CMD_RD),
        .rd_addr   (RD_ADDR),
        .rd_ba     (RD_BA),
        .ref_req   (ref_req),
        .sdram_cmd (sdram_cmd),
        .sdram_addr(sdram_addr),
        .sdram_ba  (sdram_ba)
    );

    always #5 sclk = ~sclk;

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    function automatic bit enOf(input int code);
        case (code)
            G_REF:   return ref_en;
            G_WR:    return wr_en;
            default: return rd_en;
        endcase
    endfunction

    task automatic applyStimulus(input bit wr, input bit rd);
        wr_trig = wr;
        rd_trig = rd;
        @(negedge sclk);
        wr_trig = 1'b0;
        rd_trig = 1'b0;
    endtask

    task automatic waitForGrant(input int code);
        int w;
        w = 0;
        while (!enOf(code) && w < 200) begin
            @(negedge sclk);
            w++;
        end
        if (w >= 200) checkOutput("grant timeout", 32'(code), 32'(0));
    endtask

    // Engine models: end one-cycle pulse two cycles after the start pulse, or after hold drops.
    initial forever begin
        @(negedge sclk);
        if (ref_en) begin
            repeat (2) @(negedge sclk);
            refEndEng = 1'b1;
            @(negedge sclk);
            refEndEng = 1'b0;
        end
    end

    initial forever begin
        @(negedge sclk);
        if (wr_en) begin
            int w;
            w = 0;
            while (holdWr && w < 3000) begin
                @(negedge sclk);
                w++;
            end
            repeat (2) @(negedge sclk);
            wrEndEng = 1'b1;
            @(negedge sclk);
            wrEndEng = 1'b0;
        end
    end

    initial forever begin
        @(negedge sclk);
        if (rd_en) begin
            int w;
            w = 0;
            while (holdRd && w < 3000) begin
                @(negedge sclk);
                w++;
            end
            repeat (2) @(negedge sclk);
            rdEndEng = 1'b1;
            @(negedge sclk);
            rdEndEng = 1'b0;
        end
    end

    // Monitor: pop the expected grant on every start pulse, then check the pin bus a cycle later.
    initial begin
        bit                pendCmd;
        logic [3:0]        expCmd;
        logic [ADDR_W-1:0] expAddr;
        logic [BA_W-1:0]   expBa;
        int                nEn, got, exp;
        pendCmd = 1'b0;
        expCmd  = CMD_NOP;
        expAddr = '0;
        expBa   = '0;
        forever begin
            @(negedge sclk);
            if (pendCmd) begin
                checkOutput("pin cmd after grant", 32'(sdram_cmd), 32'(expCmd));
                checkOutput("pin addr after grant", 32'(sdram_addr), 32'(expAddr));
                checkOutput("pin ba after grant", 32'(sdram_ba), 32'(expBa));
                pendCmd = 1'b0;
            end
            nEn = int'(ref_en) + int'(wr_en) + int'(rd_en);
            if (nEn != 0) begin
                got = ref_en ? G_REF : (wr_en ? G_WR : G_RD);
                if (nEn > 1) checkOutput("single start pulse", 32'(nEn), 32'(1));
                checkOutput("idle before grant", 32'(sdram_cmd), 32'(CMD_NOP));
                if (expQ.size() == 0) begin
                    checkOutput("unexpected grant", 32'(got), 32'(0));
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("grant order", 32'(got), 32'(exp));
                end
                case (got)
                    G_REF:   begin expCmd = CMD_REF; expAddr = REF_ADDR; expBa = '0;    end
                    G_WR:    begin expCmd = CMD_WR;  expAddr = WR_ADDR;  expBa = WR_BA; end
                    default: begin expCmd = CMD_RD;  expAddr = RD_ADDR;  expBa = RD_BA; end
                endcase
                pendCmd = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge sclk);
        #1;
        checkOutput("reset cmd", 32'(sdram_cmd), 32'(CMD_NOP));
        checkOutput("reset addr", 32'(sdram_addr), 32'(0));
        checkOutput("reset starts", {29'd0, ref_en, wr_en, rd_en}, 32'(0));
        checkOutput("reset ref_req", 32'(ref_req), 32'(0));
        @(negedge sclk);
        reset = 1'b1;

        // Power-up: INIT drives the init bus, IDLE shows NOP, first refresh REF_CYCLES later.
        repeat (9) @(negedge sclk);
        checkOutput("init cmd", 32'(sdram_cmd), 32'(CMD_PRE));
        checkOutput("init addr", 32'(sdram_addr), 32'(INIT_ADDR));
        init_done = 1'b1;
        expQ.push_back(G_REF);
        n = 0;
        while (!ref_req && n < 1000) begin
            @(negedge sclk);
            n++;
            if (n == 1) checkOutput("last init cycle cmd", 32'(sdram_cmd), 32'(CMD_PRE));
            if (n == 2) checkOutput("idle cmd", 32'(sdram_cmd), 32'(CMD_NOP));
            if (n == 400) checkOutput("idle cmd mid", 32'(sdram_cmd), 32'(CMD_NOP));
        end
        checkOutput("ref_req first rise", 32'(n), 32'(REF_CYCLES));
        waitForGrant(G_REF);
        @(negedge sclk);
        checkOutput("ref_req cleared", 32'(ref_req), 32'(0));
        repeat (10) @(negedge sclk);

        // Single write.
        expQ.push_back(G_WR);
        applyStimulus(1'b1, 1'b0);
        waitForGrant(G_WR);
        @(negedge sclk);
        checkOutput("wr_en one cycle", 32'(wr_en), 32'(0));
        repeat (10) @(negedge sclk);

        // Trigger on the grant edge keeps wr_pend; rd_end during WRITE is ignored.
        holdWr = 1'b1;
        expQ.push_back(G_WR);
        expQ.push_back(G_WR);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitForGrant(G_WR);
        repeat (2) @(negedge sclk);
        rdEndExtra = 1'b1;
        @(negedge sclk);
        rdEndExtra = 1'b0;
        repeat (2) @(negedge sclk);
        checkOutput("rd_end ignored in WRITE", 32'(sdram_cmd), 32'(CMD_WR));
        holdWr = 1'b0;
        repeat (4) @(negedge sclk);
        waitForGrant(G_WR);
        repeat (10) @(negedge sclk);

        // Refresh, write and read all pending together.
        holdWr = 1'b1;
        expQ.push_back(G_WR);
        applyStimulus(1'b1, 1'b0);
        waitForGrant(G_WR);
        applyStimulus(1'b1, 1'b1);
        n = 0;
        while (!ref_req && n < 1000) begin
            @(negedge sclk);
            n++;
        end
        checkOutput("ref_req during write", 32'(ref_req), 32'(1));
        expQ.push_back(G_REF);
        expQ.push_back(G_WR);
        expQ.push_back(G_RD);
        holdWr = 1'b0;
        repeat (4) @(negedge sclk);
        waitForGrant(G_RD);
        repeat (10) @(negedge sclk);

        // Four alternating triggers with both flags pending.
`ifdef SDRAM_ARB_RR_EN
        expQ.push_back(G_WR);
        expQ.push_back(G_RD);
        expQ.push_back(G_WR);
        expQ.push_back(G_RD);
        applyStimulus(1'b1, 1'b1);
        waitForGrant(G_WR);
        applyStimulus(1'b1, 1'b0);
        waitForGrant(G_RD);
        applyStimulus(1'b0, 1'b1);
        waitForGrant(G_WR);
        @(negedge sclk);
        waitForGrant(G_RD);
`else
        expQ.push_back(G_WR);
        expQ.push_back(G_WR);
        expQ.push_back(G_RD);
        expQ.push_back(G_RD);
        applyStimulus(1'b1, 1'b1);
        waitForGrant(G_WR);
        applyStimulus(1'b1, 1'b0);
        waitForGrant(G_WR);
        @(negedge sclk);
        waitForGrant(G_RD);
        applyStimulus(1'b0, 1'b1);
        waitForGrant(G_RD);
`endif
        repeat (10) @(negedge sclk);

        // Reset in the middle of a read with a write pending.
        holdRd = 1'b1;
        expQ.push_back(G_RD);
        applyStimulus(1'b0, 1'b1);
        waitForGrant(G_RD);
        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge sclk);
        reset = 1'b0;
        #1;
        checkOutput("mid-read reset rd_en", 32'(rd_en), 32'(0));
        checkOutput("mid-read reset cmd", 32'(sdram_cmd), 32'(CMD_NOP));
        checkOutput("mid-read reset addr", 32'(sdram_addr), 32'(0));
        checkOutput("mid-read reset ba", 32'(sdram_ba), 32'(0));
        checkOutput("mid-read reset ref_req", 32'(ref_req), 32'(0));
        holdRd = 1'b0;
        @(negedge sclk);
        reset = 1'b1;
        @(negedge sclk);
        checkOutput("post-reset INIT cmd", 32'(sdram_cmd), 32'(CMD_PRE));
        @(negedge sclk);
        checkOutput("post-reset IDLE cmd", 32'(sdram_cmd), 32'(CMD_NOP));
        repeat (20) @(negedge sclk);
        checkOutput("post-reset still idle", 32'(sdram_cmd), 32'(CMD_NOP));
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
